impulse_scheduler: RTL and testbench
====================================

# impulse_scheduler

Round-robin scheduler that shares one `impulse_generator` between four requesters. It sits on the generator's input side and answers the generator's `soc`/`eoc` handshake as the number source. On each generator request, it picks the next pending requester in round-robin order, latches that requester's 8-bit count onto `numero`, and acknowledges the requester. Requesters never talk to the generator directly.

## Interface
Parameters:
- `W`, default 8: width of `numero` and of each `dato_k`. It matches the generator's `numero` width.

Ports:
- `clock`  in  1  system clock. All logic is on the rising edge.
- `reset_`  in  1  synchronous, active-low reset.
- `soc`  in  1  start-of-conversion from the generator (the generator asks for a new number).
- `eoc`  out  1  end-of-conversion to the generator. High means idle or number valid.
- `numero`  out  W  count forwarded to the generator. Valid whenever `eoc`=1 after a completed handshake.
- `req`  in  4  per-requester request level. `req[k]`=1 means requester k has a count pending.
- `dato0`..`dato3`  in  W each  count of requester k. Must be stable while `req[k]`=1.
- `ack`  out  4  one-cycle grant pulse to requester k. `dato_k` is captured on that same edge.
- `grant`  out  2  index of the most recently granted requester.
- `busy`  out  1  high while a handshake with the generator is in progress (state `WAIT_LOW`).

## Operation
- States: `IDLE` and `WAIT_LOW`. Reset enters `IDLE`.
- `IDLE`:
  - `eoc`=1 and `busy`=0.
  - If `soc`=1 and `req`≠0 at a rising edge, perform a grant:
    - select k = first set bit of `req`, searching `ptr`, `ptr+1`, … mod 4;
    - `numero` ← `dato_k`, `ack[k]` ← 1, `grant` ← k;
    - `ptr` ← (k+1) mod 4, `eoc` ← 0, go to `WAIT_LOW`.
  - If `soc`=1 and `req`=0: stay in `IDLE` with `eoc`=1. The generator simply waits.
  - If `soc`=0: stay; requests are ignored.
- `WAIT_LOW`:
  - `ack` ← 0, `eoc`=0, `busy`=1.
  - When `soc`=0 is sampled: `eoc` ← 1, go to `IDLE`. `numero` is already valid at this point.
- `numero` holds its value until the next grant. It is never cleared except by reset.
- `ptr` is a 2-bit internal pointer that wraps 3→0.
- A requester that keeps `req` high after `ack` is treated as a new pending request and competes again in round-robin order.
- A `dato` value of 0 is forwarded unchanged. The scheduler adds no special case for it.
- `req` changes while in `WAIT_LOW` are ignored until the state returns to `IDLE`.
- `soc` held high indefinitely in `WAIT_LOW` keeps `eoc`=0. There is no timeout.

## Timing
- Reset (`reset_`=0 at an edge) forces, on that same edge: `eoc`=1, `numero`=0, `ack`=0, `grant`=0, `busy`=0, `ptr`=0, state `IDLE`.
- Reset wins over every other event, including reset in mid-handshake. The generator then sees `eoc` rise at the next edge.
- Grant latency: the edge that samples `soc`=1 with a pending `req` is the same edge that drives `eoc`=0, `ack[k]`=1 and the new `numero`. This is 0 extra cycles.
- The `ack` pulse lasts exactly 1 cycle.
- `eoc` returns to 1 on the first edge at which `soc`=0 is sampled in `WAIT_LOW`.
- Minimum handshake: 2 cycles with `eoc` low.
- The next grant is possible on the edge after `eoc` returns to 1, provided `soc` is already high again by then.
- Simultaneous requests: exactly one `ack` bit is ever high, and it follows the round-robin order.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- **Reset check:** assert `reset_`=0 during `WAIT_LOW` → on the next edge `eoc`=1, `ack`=0, `numero`=0, `busy`=0, `grant`=0.
- **Single requester:** `req`=0001, `dato0`=10; generator raises `soc` → `ack[0]` pulses 1 cycle, `eoc`=0. `soc` falls → `eoc`=1 and `numero`=10. The generator then emits a 10-cycle impulse.
- **Round-robin fairness:** `req`=1111 held, `dato0..3`=3,5,7,9; four back-to-back handshakes → grants in order 0,1,2,3, with `numero` sequence 3,5,7,9. A fifth handshake grants 0 again.
- **Wrap-around and skip:** `ptr`=3 after granting 2, `req`=0101 → next grant is k=0, then k=2. Requesters 1 and 3 are never acked.
- **No request:** `soc`=1 with `req`=0 for 8 cycles → `eoc` stays 1 and `ack`=0. When `req` becomes 0010 with `dato1`=4, the grant happens on that same sampled edge and `numero`=4.
- **Ignored mid-handshake changes:** `req` toggles and `dato` changes while in `WAIT_LOW` → `numero` and `ack` remain unchanged until the state returns to `IDLE`.

Source files
------------

// File: rtl/impulse_scheduler.sv
// impulse_scheduler: round-robin arbiter that lets four requesters share one
// impulse_generator. It acts as the generator's number source over the
// soc/eoc handshake and forwards the granted requester's count on numero.
module impulse_scheduler #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  output logic         eoc,
  output logic [W-1:0] numero,
  input  logic [3:0]   req,
  input  logic [W-1:0] dato0,
  input  logic [W-1:0] dato1,
  input  logic [W-1:0] dato2,
  input  logic [W-1:0] dato3,
  output logic [3:0]   ack,
  output logic [1:0]   grant,
  output logic         busy
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned PW   = 2;

  typedef enum logic {
    IDLE,
    WAIT_LOW
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic [PW-1:0] cand;
  logic          pick_valid;
  logic [W-1:0]  dato_arr [NREQ];

  assign dato_arr[0] = dato0;
  assign dato_arr[1] = dato1;
  assign dato_arr[2] = dato2;
  assign dato_arr[3] = dato3;

  // Round-robin search: first pending requester starting at ptr, wrapping mod 4.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = ptr + PW'(i);
      if (!pick_valid && req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Handshake FSM with registered outputs; grant happens on the edge that sees soc.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state  <= IDLE;
      eoc    <= 1'b1;
      numero <= '0;
      ack    <= '0;
      grant  <= '0;
      busy   <= 1'b0;
      ptr    <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          eoc  <= 1'b1;
          busy <= 1'b0;
          if (soc && pick_valid) begin
            numero <= dato_arr[pick];
            ack    <= NREQ'(1) << pick;
            grant  <= pick;
            ptr    <= pick + PW'(1);
            eoc    <= 1'b0;
            busy   <= 1'b1;
            state  <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          eoc  <= 1'b0;
          busy <= 1'b1;
          if (!soc) begin
            eoc   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          eoc   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_impulse_scheduler.sv
// Directed bench for impulse_scheduler: reset, single requester, round-robin
// order, wrap/skip, no-request waiting, and mid-handshake input changes.
module tb_impulse_scheduler;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset_;
  logic         soc;
  logic         eoc;
  logic [W-1:0] numero;
  logic [3:0]   req;
  logic [W-1:0] dato0, dato1, dato2, dato3;
  logic [3:0]   ack;
  logic [1:0]   grant;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  impulse_scheduler #(.W(W)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .soc    (soc),
    .eoc    (eoc),
    .numero (numero),
    .req    (req),
    .dato0  (dato0),
    .dato1  (dato1),
    .dato2  (dato2),
    .dato3  (dato3),
    .ack    (ack),
    .grant  (grant),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full generator handshake: soc high two edges, then low one edge.
  task automatic hs(input int k, input int num);
    soc = 1'b1;
    step();
    chk("grant_ack",   32'(ack),    32'(4'b0001 << k));
    chk("grant_eoc",   32'(eoc),    32'd0);
    chk("grant_busy",  32'(busy),   32'd1);
    chk("grant_idx",   32'(grant),  32'(k));
    chk("grant_num",   32'(numero), 32'(num));
    step();
    chk("hold_ack",    32'(ack),    32'd0);
    chk("hold_eoc",    32'(eoc),    32'd0);
    soc = 1'b0;
    step();
    chk("done_eoc",    32'(eoc),    32'd1);
    chk("done_busy",   32'(busy),   32'd0);
    chk("done_num",    32'(numero), 32'(num));
  endtask

  initial begin
    reset_ = 1'b0;
    soc    = 1'b0;
    req    = 4'b0000;
    dato0  = 8'd0;
    dato1  = 8'd0;
    dato2  = 8'd0;
    dato3  = 8'd0;
    step();
    chk("rst_eoc",   32'(eoc),    32'd1);
    chk("rst_num",   32'(numero), 32'd0);
    chk("rst_ack",   32'(ack),    32'd0);
    chk("rst_busy",  32'(busy),   32'd0);
    chk("rst_grant", 32'(grant),  32'd0);
    reset_ = 1'b1;
    step();

    // Single requester
    req   = 4'b0001;
    dato0 = 8'd10;
    hs(0, 10);

    // Reset in mid-handshake
    soc = 1'b1;
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    reset_ = 1'b0;
    step();
    chk("midrst_eoc",   32'(eoc),    32'd1);
    chk("midrst_ack",   32'(ack),    32'd0);
    chk("midrst_num",   32'(numero), 32'd0);
    chk("midrst_busy",  32'(busy),   32'd0);
    chk("midrst_grant", 32'(grant),  32'd0);
    reset_ = 1'b1;
    soc    = 1'b0;
    step();

    // Round-robin fairness with all requesting
    req   = 4'b1111;
    dato0 = 8'd3;
    dato1 = 8'd5;
    dato2 = 8'd7;
    dato3 = 8'd9;
    hs(0, 3);
    hs(1, 5);
    hs(2, 7);
    hs(3, 9);
    hs(0, 3);

    // Wrap-around and skip: bring ptr to 3, then only 0 and 2 request
    hs(1, 5);
    hs(2, 7);
    req = 4'b0101;
    hs(0, 3);
    hs(2, 7);
    hs(0, 3);

    // No request: generator waits with eoc high
    req = 4'b0000;
    soc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("noreq_eoc", 32'(eoc), 32'd1);
      chk("noreq_ack", 32'(ack), 32'd0);
    end
    req   = 4'b0010;
    dato1 = 8'd4;
    hs(1, 4);

    // Mid-handshake req/dato changes are ignored (ptr is 2 here)
    req = 4'b1111;
    soc = 1'b1;
    step();
    chk("ign_grant_ack", 32'(ack),    32'b0100);
    chk("ign_grant_num", 32'(numero), 32'd7);
    req   = 4'b0000;
    dato2 = 8'd99;
    dato0 = 8'd55;
    step();
    chk("ign1_num",   32'(numero), 32'd7);
    chk("ign1_ack",   32'(ack),    32'd0);
    chk("ign1_eoc",   32'(eoc),    32'd0);
    chk("ign1_grant", 32'(grant),  32'd2);
    req = 4'b1011;
    step();
    step();
    chk("ign2_num",   32'(numero), 32'd7);
    chk("ign2_ack",   32'(ack),    32'd0);
    chk("ign2_eoc",   32'(eoc),    32'd0);
    soc = 1'b0;
    step();
    chk("ign_done_eoc", 32'(eoc),    32'd1);
    chk("ign_done_num", 32'(numero), 32'd7);
    hs(3, 9);

    // Zero count forwarded unchanged
    req   = 4'b0001;
    dato0 = 8'd0;
    hs(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
